// File: rtl/dap_resp_arbiter.sv
// dap_resp_arbiter: round-robin, packet-locked arbiter sharing the DAP response byte stream
// Ports: hclk/hreset (sync active-high) clock and reset; en block enable (low = flush);
//   req_mask/req_tvalid/req_tdata/req_tlast/req_tready per-requester byte streams;
//   out_tvalid/out_tready/out_tdata/out_tlast/out_tid registered output stream;
//   busy stream locked to a requester; err_timeout/err_id/err_clr watchdog release report.
module dap_resp_arbiter #(
    parameter int  NUM_REQ     = 4,
    parameter int  TIMEOUT_CYC = 1024,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req_mask,
    input  logic [NUM_REQ-1:0]   req_tvalid,
    input  logic [NUM_REQ*8-1:0] req_tdata,
    input  logic [NUM_REQ-1:0]   req_tlast,
    output logic [NUM_REQ-1:0]   req_tready,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic [7:0]           out_tdata,
    output logic                 out_tlast,
    output logic [ID_W-1:0]      out_tid,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [ID_W-1:0]      err_id,
    input  logic                 err_clr
);
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nxt;
    logic [ID_W-1:0] grant, grant_nxt, last_grant, last_grant_nxt, winner, cidx;
    logic [WD_W-1:0] wd;
    logic [NUM_REQ-1:0] cand;
    logic found, hs, wd_exp;
    assign cand = req_tvalid & req_mask;
    assign busy = state == LOCKED;
    assign req_tready = (busy && en && (!out_tvalid || out_tready)) ? NUM_REQ'(1) << grant : '0;
    assign hs = req_tvalid[grant] && req_tready[grant];
    // a handshake in the expiry cycle keeps the lock
    assign wd_exp = en && busy && !hs && wd == WD_W'(TIMEOUT_CYC - 1);
    // rotating priority: first eligible requester after the previous owner
    always_comb begin
        winner = '0;
        found = 1'b0;
        cidx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cidx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && cand[cidx]) begin
                found = 1'b1;
                winner = cidx;
            end
        end
    end
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_grant_nxt = last_grant;
        if (!en)
            state_nxt = IDLE;
        else if (!busy && found) begin
            state_nxt = LOCKED;
            grant_nxt = winner;
        end else if ((hs && req_tlast[grant]) || wd_exp) begin
            state_nxt = IDLE;
            last_grant_nxt = grant;
        end
    end
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= IDLE;
            grant <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end
    always_ff @(posedge hclk) begin
        if (hreset) begin
            out_tvalid <= 1'b0;
            out_tdata <= '0;
            out_tlast <= 1'b0;
            out_tid <= '0;
            wd <= '0;
            err_timeout <= 1'b0;
            err_id <= '0;
        end else begin
            if (!en)
                out_tvalid <= 1'b0;
            else if (hs) begin
                out_tvalid <= 1'b1;
                out_tdata <= req_tdata[8*grant +: 8];
                out_tlast <= req_tlast[grant];
                out_tid <= grant;
            end else if (out_tready)
                out_tvalid <= 1'b0;
            wd <= (!en || !busy || hs || wd_exp) ? '0 : wd + 1'b1;
            if (wd_exp) begin
                err_timeout <= 1'b1;
                err_id <= grant;
            end else if (err_clr)
                err_timeout <= 1'b0;
        end
    end
endmodule
